// File: rtl/layer_pingpong_mem_if.sv
// Port bundle for the ping-pong inter-layer buffer: element writes and page
// commit from the producer, word reads and page release from the consumer.
interface layer_pingpong_mem_if #(
  parameter int ELEM_W         = 4,
  parameter int ELEMS_PER_WORD = 32,
  parameter int NUM_WORDS      = 4
);
  localparam int IA_W   = $clog2(ELEMS_PER_WORD * NUM_WORDS);
  localparam int OA_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WORD_W = ELEM_W * ELEMS_PER_WORD;

  logic              wr;
  logic [IA_W-1:0]   iaddr;
  logic [ELEM_W-1:0] idata;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd;
  logic [OA_W-1:0]   oaddr;
  logic [WORD_W-1:0] odata;
  logic              ovalid;
  logic              rd_release;
  logic              rd_ready;
  logic              err;

  modport master (
    output wr, iaddr, idata, wr_commit, rd, oaddr, rd_release,
    input  wr_ready, odata, ovalid, rd_ready, err
  );

  modport slave (
    input  wr, iaddr, idata, wr_commit, rd, oaddr, rd_release,
    output wr_ready, odata, ovalid, rd_ready, err
  );
endinterface

// File: rtl/layer_pingpong_mem.sv
// Two-page ping-pong buffer between neural-net layers: element-granular writes,
// word-granular reads, page ownership passed by commit/release handshakes.
module layer_pingpong_mem #(
  parameter int ELEM_W         = 4,
  parameter int ELEMS_PER_WORD = 32,
  parameter int NUM_WORDS      = 4
) (
  input logic                 clock,
  input logic                 reset,
  layer_pingpong_mem_if.slave bus
);
  localparam int LANE_W = $clog2(ELEMS_PER_WORD);
  localparam int OA_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WORD_W = ELEM_W * ELEMS_PER_WORD;
  localparam int DEPTH  = 2 * (1 << OA_W);

  // Page p occupies rows {p, word}; the page bit is the row MSB.
  logic [WORD_W-1:0] mem_r [DEPTH];

  logic [1:0]        full_r;
  logic              wpage_r;
  logic              rpage_r;
  logic [WORD_W-1:0] odata_r;
  logic              ovalid_r;
  logic              err_r;

  logic              wr_ready_s;
  logic              rd_ready_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              commit_ok_s;
  logic              release_ok_s;
  logic              violation_s;
  logic [1:0]        full_next_s;
  logic [LANE_W-1:0] lane_s;
  logic [OA_W-1:0]   word_s;

  assign wr_ready_s = ~full_r[wpage_r];
  assign rd_ready_s = full_r[rpage_r];
  assign lane_s     = bus.iaddr[LANE_W-1:0];
  assign word_s     = OA_W'(bus.iaddr >> LANE_W);

  // Qualify handshakes against page ownership and collect protocol violations.
  always_comb begin
    wr_ok_s      = bus.wr & wr_ready_s;
    rd_ok_s      = bus.rd & rd_ready_s;
    commit_ok_s  = bus.wr_commit & wr_ready_s;
    release_ok_s = bus.rd_release & rd_ready_s;
    violation_s  = ((bus.wr | bus.wr_commit) & ~wr_ready_s) |
                   ((bus.rd | bus.rd_release) & ~rd_ready_s);
    full_next_s  = full_r;
    // commit and release never hit the same page: that needs wpage==rpage,
    // where the page is either full (no commit) or empty (no release).
    if (commit_ok_s) begin
      full_next_s[wpage_r] = 1'b1;
    end else begin
      full_next_s[wpage_r] = full_r[wpage_r];
    end
    if (release_ok_s) begin
      full_next_s[rpage_r] = 1'b0;
    end else begin
      full_next_s[rpage_r] = full_next_s[rpage_r];
    end
  end

  // Page ownership, read port register and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_r   <= 2'b00;
      wpage_r  <= 1'b0;
      rpage_r  <= 1'b0;
      odata_r  <= {WORD_W{1'b0}};
      ovalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      full_r   <= full_next_s;
      wpage_r  <= wpage_r ^ commit_ok_s;
      rpage_r  <= rpage_r ^ release_ok_s;
      ovalid_r <= rd_ok_s;
      err_r    <= err_r | violation_s;
      if (rd_ok_s) begin
        odata_r <= mem_r[{rpage_r, bus.oaddr}];
      end
    end
  end

  // Storage is deliberately not reset; stale data stays unreadable until committed.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok_s) begin
      mem_r[{wpage_r, word_s}][lane_s*ELEM_W +: ELEM_W] <= bus.idata;
    end
  end

  assign bus.wr_ready = wr_ready_s;
  assign bus.rd_ready = rd_ready_s;
  assign bus.odata    = odata_r;
  assign bus.ovalid   = ovalid_r;
  assign bus.err      = err_r;
endmodule

// File: tb/tb_layer_pingpong_mem.sv
// Self-checking bench for layer_pingpong_mem: directed scenarios plus random
// traffic, all compared cycle by cycle against a page/element-level model.
module tb_layer_pingpong_mem;
  localparam int ELEM_W    = 4;
  localparam int EPW       = 32;
  localparam int NUM_WORDS = 4;
  localparam int WORD_W    = ELEM_W * EPW;
  localparam int NELEM     = EPW * NUM_WORDS;

  logic clock;
  logic reset;
  int   check_cnt;
  int   error_cnt;

  layer_pingpong_mem_if #(.ELEM_W(ELEM_W), .ELEMS_PER_WORD(EPW), .NUM_WORDS(NUM_WORDS)) bus ();

  layer_pingpong_mem #(.ELEM_W(ELEM_W), .ELEMS_PER_WORD(EPW), .NUM_WORDS(NUM_WORDS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: two pages of element arrays plus ownership flags.
  logic [ELEM_W-1:0] m_mem [2][NELEM];
  bit   [1:0]        m_full;
  bit                m_wp;
  bit                m_rp;
  bit                m_err;
  bit                m_ovalid;
  logic [WORD_W-1:0] m_odata;

  task automatic check_value(input string tag, input logic [WORD_W-1:0] obs,
                             input logic [WORD_W-1:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit wr_rdy;
    bit rd_rdy;
    wr_rdy = !m_full[m_wp];
    rd_rdy = m_full[m_rp];
    if (reset) begin
      m_full = 2'b00; m_wp = 1'b0; m_rp = 1'b0;
      m_err = 1'b0; m_ovalid = 1'b0; m_odata = '0;
    end else begin
      m_ovalid = 1'b0;
      if (bus.rd) begin
        if (rd_rdy) begin
          for (int k = 0; k < EPW; k++)
            m_odata[k*ELEM_W +: ELEM_W] = m_mem[m_rp][int'(bus.oaddr)*EPW + k];
          m_ovalid = 1'b1;
        end else m_err = 1'b1;
      end
      if (bus.wr) begin
        if (wr_rdy) m_mem[m_wp][int'(bus.iaddr)] = bus.idata;
        else m_err = 1'b1;
      end
      if (bus.wr_commit) begin
        if (wr_rdy) begin m_full[m_wp] = 1'b1; m_wp = !m_wp; end
        else m_err = 1'b1;
      end
      if (bus.rd_release) begin
        if (rd_rdy) begin m_full[m_rp] = 1'b0; m_rp = !m_rp; end
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_value("wr_ready", WORD_W'(bus.wr_ready), WORD_W'(!m_full[m_wp]));
    check_value("rd_ready", WORD_W'(bus.rd_ready), WORD_W'(m_full[m_rp]));
    check_value("err",      WORD_W'(bus.err),      WORD_W'(m_err));
    check_value("ovalid",   WORD_W'(bus.ovalid),   WORD_W'(m_ovalid));
    check_value("odata",    bus.odata,             m_odata);
  endtask

  task automatic idle();
    bus.wr = 1'b0; bus.wr_commit = 1'b0; bus.rd = 1'b0; bus.rd_release = 1'b0;
    bus.iaddr = '0; bus.idata = '0; bus.oaddr = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic do_write(input int addr, input int data);
    idle(); bus.wr = 1'b1; bus.iaddr = 7'(addr); bus.idata = 4'(data); tick(); idle();
  endtask

  task automatic do_commit();
    idle(); bus.wr_commit = 1'b1; tick(); idle();
  endtask

  task automatic do_release();
    idle(); bus.rd_release = 1'b1; tick(); idle();
  endtask

  task automatic do_read(input int word);
    idle(); bus.rd = 1'b1; bus.oaddr = 2'(word); tick(); idle();
  endtask

  initial begin
    check_cnt = 0; error_cnt = 0;
    m_full = 2'b00; m_wp = 1'b0; m_rp = 1'b0; m_err = 1'b0; m_ovalid = 1'b0; m_odata = '0;
    for (int p = 0; p < 2; p++) for (int i = 0; i < NELEM; i++) m_mem[p][i] = '0;
    idle();
    reset = 1'b1;
    @(posedge clock);
    do_reset();

    // Fill page 0 with address nibbles and read word 1 back.
    for (int i = 0; i < NELEM; i++) do_write(i, i);
    do_commit();
    check_value("t1_rd_ready", WORD_W'(bus.rd_ready), WORD_W'(1));
    do_read(1);
    check_value("t1_ovalid", WORD_W'(bus.ovalid), WORD_W'(1));
    check_value("t1_odata", bus.odata, 128'hFEDCBA98_76543210_FEDCBA98_76543210);

    // Fill page 1 with 3s while draining page 0, then swap.
    for (int i = 0; i < NELEM; i++) begin
      bus.wr = 1'b1; bus.iaddr = 7'(i); bus.idata = 4'h3;
      bus.rd = 1'b1; bus.oaddr = 2'(i);
      tick();
    end
    idle();
    do_commit();
    do_release();
    do_read(0);
    check_value("t3_odata", bus.odata, {32{4'h3}});

    // Both pages full: a write is dropped and flags an error.
    do_reset();
    do_commit();
    do_commit();
    check_value("t4_wr_ready", WORD_W'(bus.wr_ready), WORD_W'(0));
    do_write(0, 15);
    check_value("t4_err", WORD_W'(bus.err), WORD_W'(1));
    do_release();
    do_write(0, 15);
    do_commit();
    do_release();
    do_read(0);
    check_value("t4_lane0", WORD_W'(bus.odata[3:0]), WORD_W'(4'hF));

    // Single-lane update keeps the rest of the word.
    do_reset();
    do_write(5, 10);
    do_commit();
    do_read(0);
    check_value("t2_odata", bus.odata, 128'hFEDCBA98_76543210_FEDCBA98_76A4321F);

    // Commit and release together with one page full.
    idle(); bus.wr_commit = 1'b1; bus.rd_release = 1'b1; tick(); idle();
    check_value("t5_wr_ready", WORD_W'(bus.wr_ready), WORD_W'(1));
    check_value("t5_rd_ready", WORD_W'(bus.rd_ready), WORD_W'(1));
    check_value("t5_err", WORD_W'(bus.err), WORD_W'(0));

    // Reset in the middle of filling a page.
    for (int i = 0; i < 10; i++) do_write(i + 40, i);
    do_reset();
    check_value("t6_wr_ready", WORD_W'(bus.wr_ready), WORD_W'(1));
    check_value("t6_rd_ready", WORD_W'(bus.rd_ready), WORD_W'(0));
    check_value("t6_ovalid", WORD_W'(bus.ovalid), WORD_W'(0));
    check_value("t6_odata", bus.odata, '0);
    check_value("t6_err", WORD_W'(bus.err), WORD_W'(0));
    do_read(0);
    check_value("t6_err_rd", WORD_W'(bus.err), WORD_W'(1));

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      bus.wr         = ($urandom_range(99) < 70);
      bus.iaddr      = 7'($urandom_range(NELEM - 1));
      bus.idata      = 4'($urandom);
      bus.wr_commit  = ($urandom_range(99) < 4);
      bus.rd         = ($urandom_range(99) < 60);
      bus.oaddr      = 2'($urandom_range(NUM_WORDS - 1));
      bus.rd_release = ($urandom_range(99) < 4);
      reset          = ($urandom_range(999) < 3);
      tick();
    end
    reset = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end
endmodule
